audio_arbiter: RTL and testbench

Sequencer and arbiter for the single audio output of the smart clock. It accepts hourly-chime and alarm requests from the clock core and grants the speaker to one of them at a time. It times the hourly strike pattern and alarm duration from a 1 Hz tick, and handles snooze and stop buttons. The block sits between the clock core's event outputs and the media tone generator, and drives that generator's enable and tone select.

---
 rtl/smart_clock_pkg.sv | 32 +++
 rtl/sec_timer.sv | 34 +++
 rtl/audio_arbiter.sv | 177 +++++++++++++++++
 tb/tb_audio_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_clock_pkg.sv
// rtl/smart_clock_pkg.sv - shared audio FSM states, tone encodings and BCD hour helpers
package smart_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHIME_ON,
    ST_CHIME_OFF,
    ST_ALARM,
    ST_SNOOZE
  } audio_state_e;

  localparam logic [1:0] TONE_NONE  = 2'b00;
  localparam logic [1:0] TONE_CHIME = 2'b01;
  localparam logic [1:0] TONE_ALARM = 2'b10;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam int         TIMER_W      = 10;
  localparam int         SNOOZE_CNT_W = 4;

  function automatic logic bcd_hour_valid(input logic [7:0] h);
    return (h[3:0] <= 4'd9) && (h <= BCD_HOUR_MAX);
  endfunction

  // 12-hour strike count; only meaningful for a valid hour, where hour 0 strikes 12
  function automatic logic [3:0] bcd_hour_strikes(input logic [7:0] h);
    logic [4:0] bin;
    bin = 5'(h[5:4]) * 5'd10 + 5'(h[3:0]);
    if (bin >= 5'd12) bin = bin - 5'd12;
    return (bin == 5'd0) ? 4'd12 : bin[3:0];
  endfunction

endpackage

// File: rtl/sec_timer.sv
// rtl/sec_timer.sv - 10-bit loadable down-counter stepped by the 1 Hz tick, saturating at 0
module sec_timer
  import smart_clock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               sec_tick_i,
  output logic               done_o,
  output logic               last_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // A load wins over a same-cycle tick, so the entry tick is never counted
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (sec_tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done_o = (count_q == '0);
  assign last_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/audio_arbiter.sv
// rtl/audio_arbiter.sv - chime/alarm speaker arbiter and sequencer; snooze present when SMART_CLOCK_SNOOZE_EN is defined
module audio_arbiter
  import smart_clock_pkg::*;
#(
  parameter int ALARM_SECS  = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       on_the_hour,
  input  logic       on_alarm,
  input  logic [7:0] hour_bcd,
  input  logic       snooze_n,
  input  logic       stop_n,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic       busy,
  output logic       snooze_active
);

  localparam logic [TIMER_W-1:0] ALARM_LOAD  = TIMER_W'(ALARM_SECS);
  localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_SECS);
  localparam logic [TIMER_W-1:0] PHASE_LOAD  = TIMER_W'(1);

  audio_state_e       state_q, state_d;
  logic [3:0]         strikes_q, strikes_d;
  logic               stop_prev_q, stop_press_q;
  logic               tone_en_q, busy_q;
  logic [1:0]         tone_sel_q, tone_sel_d;
  logic               tmr_load, tmr_done, tmr_last, tmr_expire;
  logic [TIMER_W-1:0] tmr_val;
  logic               snz_ok, snz_clr, snz_inc;

  sec_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .sec_tick_i (sec_tick),
    .done_o     (tmr_done),
    .last_o     (tmr_last)
  );

  // Expiry is seen on the tick that takes the count to zero, keeping outputs one cycle behind the tick
  assign tmr_expire = sec_tick && (tmr_last || tmr_done);

`ifdef SMART_CLOCK_SNOOZE_EN
  logic                    snz_prev_q, snz_press_q, snooze_active_q;
  logic [SNOOZE_CNT_W-1:0] snz_cnt_q, snz_cnt_d;

  always_comb begin
    snz_cnt_d = snz_cnt_q;
    if (snz_clr)      snz_cnt_d = '0;
    else if (snz_inc) snz_cnt_d = snz_cnt_q + SNOOZE_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_prev_q      <= 1'b1;
      snz_press_q     <= 1'b0;
      snz_cnt_q       <= '0;
      snooze_active_q <= 1'b0;
    end else begin
      snz_prev_q      <= snooze_n;
      snz_press_q     <= snz_prev_q & ~snooze_n;
      snz_cnt_q       <= snz_cnt_d;
      snooze_active_q <= (state_d == ST_SNOOZE);
    end
  end

  assign snz_ok        = snz_press_q && (snz_cnt_q < SNOOZE_CNT_W'(MAX_SNOOZE));
  assign snooze_active = snooze_active_q;
`else
  logic unused_snz;
  assign unused_snz    = snooze_n ^ snz_clr ^ snz_inc ^ (MAX_SNOOZE != 0);
  assign snz_ok        = 1'b0;
  assign snooze_active = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    strikes_d  = strikes_q;
    tmr_load   = 1'b0;
    tmr_val    = PHASE_LOAD;
    snz_clr    = 1'b0;
    snz_inc    = 1'b0;
    tone_sel_d = TONE_NONE;

    if ((state_q != ST_IDLE) && stop_press_q) begin
      state_d = ST_IDLE;
      snz_clr = 1'b1;
    end else if (on_alarm) begin
      state_d  = ST_ALARM;
      tmr_load = 1'b1;
      tmr_val  = ALARM_LOAD;
      snz_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (on_the_hour && bcd_hour_valid(hour_bcd)) begin
            state_d   = ST_CHIME_ON;
            strikes_d = bcd_hour_strikes(hour_bcd);
            tmr_load  = 1'b1;
          end
        end
        ST_CHIME_ON: begin
          if (tmr_expire) begin
            state_d  = ST_CHIME_OFF;
            tmr_load = 1'b1;
          end
        end
        ST_CHIME_OFF: begin
          if (tmr_expire) begin
            strikes_d = (strikes_q != 4'd0) ? strikes_q - 4'd1 : 4'd0;
            if (strikes_q <= 4'd1) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_CHIME_ON;
              tmr_load = 1'b1;
            end
          end
        end
        ST_ALARM: begin
          if (snz_ok) begin
            state_d  = ST_SNOOZE;
            tmr_load = 1'b1;
            tmr_val  = SNOOZE_LOAD;
            snz_inc  = 1'b1;
          end else if (tmr_expire) begin
            state_d = ST_IDLE;
          end
        end
        ST_SNOOZE: begin
          if (tmr_expire) begin
            state_d  = ST_ALARM;
            tmr_load = 1'b1;
            tmr_val  = ALARM_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_d)
      ST_CHIME_ON: tone_sel_d = TONE_CHIME;
      ST_ALARM:    tone_sel_d = TONE_ALARM;
      default:     tone_sel_d = TONE_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      strikes_q    <= 4'd0;
      stop_prev_q  <= 1'b1;
      stop_press_q <= 1'b0;
      tone_en_q    <= 1'b0;
      tone_sel_q   <= TONE_NONE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      strikes_q    <= strikes_d;
      stop_prev_q  <= stop_n;
      stop_press_q <= stop_prev_q & ~stop_n;
      tone_en_q    <= (tone_sel_d != TONE_NONE);
      tone_sel_q   <= tone_sel_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign tone_en  = tone_en_q;
  assign tone_sel = tone_sel_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_audio_arbiter.sv
// tb/tb_audio_arbiter.sv - self-checking bench for audio_arbiter: chime table, directed corners, random vs model
`timescale 1ns/1ps
module tb_audio_arbiter;

  localparam int A_SECS = 5;
  localparam int S_SECS = 3;
  localparam int M_SNZ  = 2;
`ifdef SMART_CLOCK_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_CHIME = 1, M_ALARM = 2, M_SNOOZE = 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sec_tick = 1'b0, on_the_hour = 1'b0, on_alarm = 1'b0;
  logic [7:0] hour_bcd = 8'h00;
  logic       snooze_n = 1'b1, stop_n = 1'b1;
  logic       tone_en, busy, snooze_active;
  logic [1:0] tone_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: chime tracked as remaining half-strike ticks, tone on when even
  int m_mode, m_rem, m_k, m_scnt;
  bit h1, h2, s1, s2;

  typedef struct {
    logic [7:0] hour;
    int         strikes;
  } chime_vec_t;
  chime_vec_t vec[10];

  always #5 clk = ~clk;

  audio_arbiter #(.ALARM_SECS(A_SECS), .SNOOZE_SECS(S_SECS), .MAX_SNOOZE(M_SNZ)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .on_the_hour(on_the_hour),
    .on_alarm(on_alarm), .hour_bcd(hour_bcd), .snooze_n(snooze_n), .stop_n(stop_n),
    .tone_en(tone_en), .tone_sel(tone_sel), .busy(busy), .snooze_active(snooze_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  function automatic int strikes_of(input logic [7:0] h);
    int hi, lo, v;
    hi = int'(h[7:4]);
    lo = int'(h[3:0]);
    if (lo > 9 || hi > 9) return 0;
    v = hi * 10 + lo;
    if (v > 23) return 0;
    return (v % 12 == 0) ? 12 : v % 12;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_edge();
    bit stp, snz;
    int n;
    stp = h2 && !h1;
    snz = s2 && !s1;
    h2 = h1; h1 = stop_n;
    s2 = s1; s1 = snooze_n;
    n = strikes_of(hour_bcd);
    if (m_mode != M_IDLE && stp) begin
      m_mode = M_IDLE; m_scnt = 0;
    end else if (on_alarm) begin
      m_mode = M_ALARM; m_rem = A_SECS; m_scnt = 0;
    end else if (m_mode == M_IDLE) begin
      if (on_the_hour && n > 0) begin
        m_mode = M_CHIME; m_k = 2 * n;
      end
    end else if (m_mode == M_ALARM && snz && SNZ_EN && m_scnt < M_SNZ) begin
      m_mode = M_SNOOZE; m_rem = S_SECS; m_scnt++;
    end else if (sec_tick) begin
      m_rem--;
      m_k--;
      if (m_mode == M_CHIME && m_k == 0) m_mode = M_IDLE;
      else if (m_mode == M_ALARM && m_rem == 0) m_mode = M_IDLE;
      else if (m_mode == M_SNOOZE && m_rem == 0) begin
        m_mode = M_ALARM; m_rem = A_SECS;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] sel;
    sel = 2'b00;
    if (m_mode == M_CHIME && (m_k % 2 == 0)) sel = 2'b01;
    if (m_mode == M_ALARM) sel = 2'b10;
    return {sel != 2'b00, sel, m_mode != M_IDLE, m_mode == M_SNOOZE};
  endfunction

  task automatic run_chime(input logic [7:0] h, output int strikes, output int ticks);
    logic [1:0] prev;
    strikes = 0;
    ticks   = 0;
    prev    = 2'b00;
    hour_bcd = h; on_the_hour = 1'b1;
    step();
    on_the_hour = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (tone_sel == 2'b01 && prev != 2'b01) strikes++;
      prev = tone_sel;
      if (i % 2 == 0) begin
        ticks++;
        tick_step();
      end else begin
        step();
      end
    end
  endtask

  initial begin
    int st, tk, n, seen;
    logic acc;

    vec[0] = '{8'h15, 3};  vec[1] = '{8'h00, 12}; vec[2] = '{8'h12, 12};
    vec[3] = '{8'h13, 1};  vec[4] = '{8'h23, 11}; vec[5] = '{8'h09, 9};
    vec[6] = '{8'h11, 11}; vec[7] = '{8'h1A, 0};  vec[8] = '{8'h24, 0};
    vec[9] = '{8'hA1, 0};

    step(); step();
    check("reset_outputs", {tone_en, tone_sel, busy, snooze_active}, 5'd0);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {tone_en, tone_sel, busy, snooze_active}, 5'd0);

    foreach (vec[i]) begin
      run_chime(vec[i].hour, st, tk);
      check($sformatf("chime_strikes_%02h", vec[i].hour), st, vec[i].strikes);
      check($sformatf("chime_ticks_%02h", vec[i].hour), tk, 2 * vec[i].strikes);
      check($sformatf("chime_idle_%02h", vec[i].hour), busy, 1'b0);
      step();
    end

    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    check("alarm_start", {tone_en, tone_sel}, 3'b110);
    n = 0;
    for (int i = 0; i < 20 && tone_en; i++) begin
      tick_step();
      n++;
      if (tone_en) step();
    end
    check("alarm_ticks", n, A_SECS);
    check("alarm_end", {tone_en, tone_sel, busy}, 4'd0);

    hour_bcd = 8'h04; on_the_hour = 1'b1; step(); on_the_hour = 1'b0;
    tick_step(); tick_step();
    check("preempt_strike2", tone_sel, 2'b01);
    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    check("preempt_alarm", tone_sel, 2'b10);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) tick_step(); else step();
      if (tone_sel == 2'b01) seen++;
    end
    check("preempt_no_strikes", seen, 0);
    check("preempt_end", busy, 1'b0);

    hour_bcd = 8'h05; on_alarm = 1'b1; on_the_hour = 1'b1; step();
    on_alarm = 1'b0; on_the_hour = 1'b0;
    check("simultaneous", tone_sel, 2'b10);
    stop_n = 1'b0; step();
    check("stop_latency1", busy, 1'b1);
    step();
    check("stop_press", busy, 1'b0);
    stop_n = 1'b1; step();

`ifdef SMART_CLOCK_SNOOZE_EN
    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    for (int k = 0; k < 2; k++) begin
      snooze_n = 1'b0; step(); step(); snooze_n = 1'b1;
      check($sformatf("snooze%0d_enter", k), {tone_en, snooze_active}, 2'b01);
      tick_step(); step(); tick_step(); step();
      check($sformatf("snooze%0d_hold", k), snooze_active, 1'b1);
      tick_step();
      check($sformatf("snooze%0d_resume", k), {tone_sel, snooze_active}, 3'b100);
    end
    snooze_n = 1'b0; step(); step(); snooze_n = 1'b1;
    check("snooze_limit", {tone_sel, snooze_active}, 3'b100);
    stop_n = 1'b0; snooze_n = 1'b0; step(); step();
    check("stop_and_snooze", {busy, snooze_active}, 2'b00);
    stop_n = 1'b1; snooze_n = 1'b1; step();
    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    snooze_n = 1'b0; step(); step(); snooze_n = 1'b1;
    check("snooze_before_stop", snooze_active, 1'b1);
    stop_n = 1'b0; step(); step(); stop_n = 1'b1;
    check("stop_in_snooze", {busy, snooze_active}, 2'b00);
    step();
`else
    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    snooze_n = 1'b0; step(); step(); snooze_n = 1'b1;
    check("snooze_ignored", {tone_sel, snooze_active}, 3'b100);
    stop_n = 1'b0; snooze_n = 1'b0; step(); step();
    check("stop_and_snooze", busy, 1'b0);
    stop_n = 1'b1; snooze_n = 1'b1; step();
`endif

    on_alarm = 1'b1; step(); on_alarm = 1'b0;
    tick_step();
    rst_n = 1'b0;
    #1;
    check("reset_mid_alarm", {tone_en, tone_sel, busy, snooze_active}, 5'd0);
    step(); step();
    rst_n = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) tick_step(); else step();
      acc = acc | busy | tone_en;
    end
    check("idle_after_reset_release", acc, 1'b0);

    rst_n = 1'b0; step();
    m_mode = M_IDLE; m_rem = 0; m_k = 0; m_scnt = 0;
    h1 = 1'b1; h2 = 1'b1; s1 = 1'b1; s2 = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      sec_tick    = ($urandom_range(0, 2) == 0);
      on_the_hour = ($urandom_range(0, 39) == 0);
      on_alarm    = ($urandom_range(0, 99) == 0);
      hour_bcd    = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 23))) : 8'($urandom);
      if ($urandom_range(0, 5) == 0)  snooze_n = ~snooze_n;
      if ($urandom_range(0, 59) == 0) stop_n = ~stop_n;
      model_edge();
      step();
      check($sformatf("random_cycle_%0d", c), {tone_en, tone_sel, busy, snooze_active}, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
